// File: rtl/clock_pkg.sv
// clock_pkg: shared constants, types and helpers for the HH:MM:SS time-set block.
//   SOD_W / sod_t      : second-of-day width and type (0..86399 fits in 17 bits)
//   SECS_PER_*         : unit conversion constants
//   state_t            : time-set FSM states
//   field_t            : encoding of the field_sel output
//   wrap_step()        : +/-1 with wrap-around at 0 and a field maximum
//   hms_to_sod()       : hour/minute/second to second-of-day
package clock_pkg;

    localparam int unsigned SOD_W         = 17;
    localparam int unsigned SECS_PER_DAY  = 86400;
    localparam int unsigned SECS_PER_HOUR = 3600;
    localparam int unsigned SECS_PER_MIN  = 60;
    localparam int unsigned HOUR_MAX      = 23;
    localparam int unsigned MINSEC_MAX    = 59;

    typedef logic [SOD_W-1:0] sod_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SET_HH,
        ST_SET_MM,
        ST_SET_SS,
        ST_COMMIT
    } state_t;

    typedef enum logic [1:0] {
        FIELD_NONE = 2'd0,
        FIELD_HH   = 2'd1,
        FIELD_MM   = 2'd2,
        FIELD_SS   = 2'd3
    } field_t;

    function automatic logic [5:0] wrap_step(input logic [5:0] v,
                                             input logic [5:0] max,
                                             input logic       up);
        if (up)
            return (v == max) ? 6'd0 : v + 6'd1;
        else
            return (v == 6'd0) ? max : v - 6'd1;
    endfunction

    function automatic sod_t hms_to_sod(input logic [4:0] h,
                                        input logic [5:0] m,
                                        input logic [5:0] s);
        return sod_t'(h) * sod_t'(SECS_PER_HOUR)
             + sod_t'(m) * sod_t'(SECS_PER_MIN)
             + sod_t'(s);
    endfunction

endpackage

// File: rtl/clock_time_set_btn_debounce.sv
// btn_debounce: one push-button front end.
//   clk, reset : clock, synchronous active-high reset
//   raw        : asynchronous raw button level (high = pressed)
//   rep_en     : (CLOCK_TIME_SET_AUTO_REPEAT_EN only) allow auto-repeat while held
//   press      : one-cycle pulse per accepted press (plus repeats when enabled)
// The debounced level flips after DEBOUNCE_CYCLES consecutive cycles of the
// synchronized level disagreeing with it; press fires one cycle after the
// debounced rising edge. Releases produce nothing.
// Optional macro: CLOCK_TIME_SET_AUTO_REPEAT_EN adds the hold-to-repeat timer.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
`ifdef CLOCK_TIME_SET_AUTO_REPEAT_EN
   ,parameter int unsigned REPEAT_DELAY_CYCLES  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD_CYCLES = 5_000_000
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
`ifdef CLOCK_TIME_SET_AUTO_REPEAT_EN
    input  logic rep_en,
`endif
    output logic press
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic          db;
    logic          db_q;
    logic          press_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync    <= '0;
            db      <= 1'b0;
            db_q    <= 1'b0;
            press_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync    <= {sync[0], raw};
            db_q    <= db;
            press_q <= db & ~db_q;
            if (sync[1] == db) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                db  <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef CLOCK_TIME_SET_AUTO_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                   REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int unsigned RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rep_cnt;
    logic          rep_pulse;

    // Reloaded with the initial delay on the press itself and whenever the
    // hold is broken, so the first repeat lands REPEAT_DELAY_CYCLES after press.
    always_ff @(posedge clk) begin
        if (reset) begin
            rep_cnt   <= '0;
            rep_pulse <= 1'b0;
        end else begin
            rep_pulse <= 1'b0;
            if (!rep_en || !db || press_q) begin
                rep_cnt <= RW'(REPEAT_DELAY_CYCLES - 1);
            end else if (rep_cnt == '0) begin
                rep_pulse <= 1'b1;
                rep_cnt   <= RW'(REPEAT_PERIOD_CYCLES - 1);
            end else begin
                rep_cnt <= rep_cnt - 1'b1;
            end
        end
    end

    assign press = press_q | rep_pulse;
`else
    assign press = press_q;
`endif

endmodule

// File: rtl/clock_time_set.sv
// clock_time_set: time-entry front end for the HH:MM:SS clock.
//   clk, reset          : clock, synchronous active-high reset
//   btn_mode/inc/dec    : raw push-buttons (high = pressed)
//   cur_seconds         : live second-of-day from the clock counter
//   load_valid          : one-cycle strobe, load load_seconds into the counter
//   load_seconds        : committed second-of-day, held until next commit
//   editing             : high in every state but IDLE
//   field_sel           : 0 none, 1 HH, 2 MM, 3 SS
//   edit_hour/minute/second : fields being edited, exported for display
// Optional macro: CLOCK_TIME_SET_AUTO_REPEAT_EN (hold inc/dec to auto-repeat).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for mode; fields keep their last values
// ST_CAPTURE | split the latched second-of-day into h/m/s, one step per cycle
// ST_SET_HH  | editing hours
// ST_SET_MM  | editing minutes
// ST_SET_SS  | editing seconds
// ST_COMMIT  | load_valid strobe with the assembled second-of-day
module clock_time_set
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES     = 500_000,
    parameter int unsigned EDIT_TIMEOUT_CYCLES = 500_000_000
`ifdef CLOCK_TIME_SET_AUTO_REPEAT_EN
   ,parameter int unsigned REPEAT_DELAY_CYCLES  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD_CYCLES = 5_000_000
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_mode,
    input  logic             btn_inc,
    input  logic             btn_dec,
    input  logic [SOD_W-1:0] cur_seconds,
    output logic             load_valid,
    output logic [SOD_W-1:0] load_seconds,
    output logic             editing,
    output logic [1:0]       field_sel,
    output logic [4:0]       edit_hour,
    output logic [5:0]       edit_minute,
    output logic [5:0]       edit_second
);
    localparam int unsigned TW = $clog2(EDIT_TIMEOUT_CYCLES + 1);

    state_t        state, state_next;
    field_t        sel;
    sod_t          work;
    logic [TW-1:0] tmo_cnt;
    logic          mode_ev, inc_ev, dec_ev;
    logic          act_inc, act_dec, accepted, step_up;

`ifdef CLOCK_TIME_SET_AUTO_REPEAT_EN
    logic rep_en;
    assign rep_en = (state == ST_SET_HH || state == ST_SET_MM || state == ST_SET_SS)
                    && (state_next == state);

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                   .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
                   .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES))
        u_db_mode (.clk(clk), .reset(reset), .raw(btn_mode), .rep_en(1'b0),   .press(mode_ev));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                   .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
                   .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES))
        u_db_inc  (.clk(clk), .reset(reset), .raw(btn_inc),  .rep_en(rep_en), .press(inc_ev));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                   .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
                   .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES))
        u_db_dec  (.clk(clk), .reset(reset), .raw(btn_dec),  .rep_en(rep_en), .press(dec_ev));
`else
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
        u_db_mode (.clk(clk), .reset(reset), .raw(btn_mode), .press(mode_ev));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
        u_db_inc  (.clk(clk), .reset(reset), .raw(btn_inc),  .press(inc_ev));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
        u_db_dec  (.clk(clk), .reset(reset), .raw(btn_dec),  .press(dec_ev));
`endif

    // mode beats inc/dec; inc together with dec cancels both.
    assign act_inc  = ~mode_ev & inc_ev & ~dec_ev;
    assign act_dec  = ~mode_ev & dec_ev & ~inc_ev;
    assign accepted = mode_ev | act_inc | act_dec;
    assign step_up  = act_inc;

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        editing    = (state != ST_IDLE);
        sel        = FIELD_NONE;
        load_valid = 1'b0;
        unique case (state)
            ST_IDLE:    if (mode_ev) state_next = ST_CAPTURE;
            ST_CAPTURE: if (work < sod_t'(SECS_PER_MIN)) state_next = ST_SET_HH;
            ST_SET_HH: begin
                sel = FIELD_HH;
                if (mode_ev)                             state_next = ST_SET_MM;
                else if (!accepted && tmo_cnt == '0)     state_next = ST_IDLE;
            end
            ST_SET_MM: begin
                sel = FIELD_MM;
                if (mode_ev)                             state_next = ST_SET_SS;
                else if (!accepted && tmo_cnt == '0)     state_next = ST_IDLE;
            end
            ST_SET_SS: begin
                sel = FIELD_SS;
                if (mode_ev)                             state_next = ST_COMMIT;
                else if (!accepted && tmo_cnt == '0)     state_next = ST_IDLE;
            end
            ST_COMMIT: begin
                load_valid = 1'b1;
                state_next = ST_IDLE;
            end
            default:    state_next = ST_IDLE;
        endcase
    end

    assign field_sel = sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            work         <= '0;
            edit_hour    <= '0;
            edit_minute  <= '0;
            edit_second  <= '0;
            tmo_cnt      <= '0;
            load_seconds <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    tmo_cnt <= '0;
                    if (mode_ev) begin
                        work        <= cur_seconds;
                        edit_hour   <= '0;
                        edit_minute <= '0;
                        edit_second <= '0;
                    end
                end
                ST_CAPTURE: begin
                    // Timeout window opens on entry to SET_HH.
                    tmo_cnt <= TW'(EDIT_TIMEOUT_CYCLES - 1);
                    if (work >= sod_t'(SECS_PER_DAY)) begin
                        work <= work - sod_t'(SECS_PER_DAY);
                    end else if (work >= sod_t'(SECS_PER_HOUR)) begin
                        work      <= work - sod_t'(SECS_PER_HOUR);
                        edit_hour <= edit_hour + 5'd1;
                    end else if (work >= sod_t'(SECS_PER_MIN)) begin
                        work        <= work - sod_t'(SECS_PER_MIN);
                        edit_minute <= edit_minute + 6'd1;
                    end else begin
                        edit_second <= work[5:0];
                    end
                end
                ST_SET_HH, ST_SET_MM, ST_SET_SS: begin
                    if (accepted)
                        tmo_cnt <= TW'(EDIT_TIMEOUT_CYCLES - 1);
                    else if (tmo_cnt != '0)
                        tmo_cnt <= tmo_cnt - 1'b1;
                    if (act_inc || act_dec) begin
                        if (state == ST_SET_HH)
                            edit_hour <= 5'(wrap_step({1'b0, edit_hour}, 6'(HOUR_MAX), step_up));
                        else if (state == ST_SET_MM)
                            edit_minute <= wrap_step(edit_minute, 6'(MINSEC_MAX), step_up);
                        else
                            edit_second <= wrap_step(edit_second, 6'(MINSEC_MAX), step_up);
                    end
                    if (state == ST_SET_SS && mode_ev)
                        load_seconds <= hms_to_sod(edit_hour, edit_minute, edit_second);
                end
                default: ;
            endcase
        end
    end

endmodule
